// File: rtl/ball_motion_ctrl_if.sv
// Signal bundle between the ball motion controller and its datapath neighbours
// (collision checkers, VGA plotter). Clock and reset stay outside the bundle.
interface ball_motion_ctrl_if;
    logic       start;
    logic       frame_tick;
    logic [1:0] edge_coll;
    logic [1:0] obj_coll;
    logic       draw_ack;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [6:0] xstep;
    logic [6:0] ystep;
    logic [1:0] dir;
    logic       draw_req;
    logic       ball_lost;
    logic       tick_overrun;

    modport slave (
        input  start, frame_tick, edge_coll, obj_coll, draw_ack,
        output ball_x, ball_y, xstep, ystep, dir, draw_req, ball_lost, tick_overrun
    );

    modport master (
        output start, frame_tick, edge_coll, obj_coll, draw_ack,
        input  ball_x, ball_y, xstep, ystep, dir, draw_req, ball_lost, tick_overrun
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball position/direction controller: settle, evaluate bounces, move, draw.
// Optional BALL_SPEEDUP_EN: every 4 object hits raise xstep/ystep by 1 (saturating at 15).
module ball_motion_ctrl #(
    parameter int         X_START       = 320,
    parameter int         Y_START       = 240,
    parameter int         X_MAX         = 639,
    parameter int         Y_MAX         = 479,
    parameter int         STEP_INIT     = 2,
    parameter logic [1:0] DIR_INIT      = 2'b00,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    ball_motion_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_SETTLE, S_EVAL, S_MOVE, S_DRAW
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [9:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic [1:0] r_dir, w_dir_nxt;
    logic       r_req, w_req_nxt;
    logic       r_lost, w_lost_nxt;
    logic       r_ovr, w_ovr_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic [6:0] w_xstep, w_ystep;

    logic       w_xhit, w_yhit, w_loss;
    logic [10:0] w_xsum, w_ysum;
    logic [9:0] w_xinc, w_xdec, w_yinc, w_ydec;

`ifdef BALL_SPEEDUP_EN
    logic [6:0] r_xstep, r_ystep, w_xstep_nxt, w_ystep_nxt;
    logic [2:0] r_bcnt, w_bcnt_nxt;
    assign w_xstep = r_xstep;
    assign w_ystep = r_ystep;
`else
    assign w_xstep = 7'(STEP_INIT);
    assign w_ystep = 7'(STEP_INIT);
`endif

    // Hit code: [1]=hit, [0]=axis (0 X, 1 Y); OR across sources so a shared axis toggles once
    assign w_xhit = (bus.edge_coll == 2'b10) || (bus.obj_coll == 2'b10);
    assign w_yhit = (bus.edge_coll == 2'b11) || (bus.obj_coll == 2'b11);
    assign w_loss = (bus.edge_coll == 2'b11) && !r_dir[1];

    assign w_xsum = {1'b0, r_x} + {4'b0, w_xstep};
    assign w_ysum = {1'b0, r_y} + {4'b0, w_ystep};
    assign w_xinc = (w_xsum > 11'(X_MAX)) ? 10'(X_MAX) : w_xsum[9:0];
    assign w_yinc = (w_ysum > 11'(Y_MAX)) ? 10'(Y_MAX) : w_ysum[9:0];
    assign w_xdec = (r_x < {3'b0, w_xstep}) ? 10'd0 : r_x - {3'b0, w_xstep};
    assign w_ydec = (r_y < {3'b0, w_ystep}) ? 10'd0 : r_y - {3'b0, w_ystep};

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dir_nxt   = r_dir;
        w_req_nxt   = r_req;
        w_lost_nxt  = 1'b0;
        w_ovr_nxt   = r_ovr;
        w_cnt_nxt   = r_cnt;
`ifdef BALL_SPEEDUP_EN
        w_xstep_nxt = r_xstep;
        w_ystep_nxt = r_ystep;
        w_bcnt_nxt  = r_bcnt;
`endif
        // WAIT consumes the tick; IDLE ignores it silently
        if (bus.frame_tick && r_state != S_IDLE && r_state != S_WAIT)
            w_ovr_nxt = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.frame_tick) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = 3'd0;
                end
            end
            S_SETTLE: begin
                if (r_cnt == 3'(SETTLE_CYCLES - 1)) w_state_nxt = S_EVAL;
                else                                w_cnt_nxt   = r_cnt + 3'd1;
            end
            S_EVAL: begin
                if (w_loss) begin
                    w_lost_nxt  = 1'b1;
                    w_x_nxt     = 10'(X_START);
                    w_y_nxt     = 10'(Y_START);
                    w_dir_nxt   = DIR_INIT;
                    w_state_nxt = S_IDLE;
`ifdef BALL_SPEEDUP_EN
                    w_xstep_nxt = 7'(STEP_INIT);
                    w_ystep_nxt = 7'(STEP_INIT);
                    w_bcnt_nxt  = 3'd0;
`endif
                end else begin
                    w_dir_nxt   = r_dir ^ {w_yhit, w_xhit};
                    w_state_nxt = S_MOVE;
`ifdef BALL_SPEEDUP_EN
                    if (bus.obj_coll[1]) begin
                        if (r_bcnt == 3'd3) begin
                            w_bcnt_nxt  = 3'd0;
                            w_xstep_nxt = (r_xstep >= 7'd15) ? r_xstep : r_xstep + 7'd1;
                            w_ystep_nxt = (r_ystep >= 7'd15) ? r_ystep : r_ystep + 7'd1;
                        end else begin
                            w_bcnt_nxt  = r_bcnt + 3'd1;
                        end
                    end
`endif
                end
            end
            S_MOVE: begin
                w_x_nxt     = r_dir[0] ? w_xdec : w_xinc;
                w_y_nxt     = r_dir[1] ? w_ydec : w_yinc;
                w_req_nxt   = 1'b1;
                w_state_nxt = S_DRAW;
            end
            S_DRAW: begin
                if (bus.draw_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_WAIT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= 10'(X_START);
            r_y     <= 10'(Y_START);
            r_dir   <= DIR_INIT;
            r_req   <= 1'b0;
            r_lost  <= 1'b0;
            r_ovr   <= 1'b0;
            r_cnt   <= 3'd0;
`ifdef BALL_SPEEDUP_EN
            r_xstep <= 7'(STEP_INIT);
            r_ystep <= 7'(STEP_INIT);
            r_bcnt  <= 3'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_dir   <= w_dir_nxt;
            r_req   <= w_req_nxt;
            r_lost  <= w_lost_nxt;
            r_ovr   <= w_ovr_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef BALL_SPEEDUP_EN
            r_xstep <= w_xstep_nxt;
            r_ystep <= w_ystep_nxt;
            r_bcnt  <= w_bcnt_nxt;
`endif
        end
    end

    assign bus.ball_x       = r_x;
    assign bus.ball_y       = r_y;
    assign bus.xstep        = w_xstep;
    assign bus.ystep        = w_ystep;
    assign bus.dir          = r_dir;
    assign bus.draw_req     = r_req;
    assign bus.ball_lost    = r_lost;
    assign bus.tick_overrun = r_ovr;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: directed walks to the field edges plus
// random collision frames, checked against a plain-arithmetic ball model.
module tb_ball_motion_ctrl;
    localparam int SC = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ball_motion_ctrl_if bus();

    ball_motion_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference ball state
    int   mx, my;
    logic [1:0] mdir;
    bit   m_idle;

    task automatic model_reset();
        mx = 320; my = 240; mdir = 2'b00; m_idle = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        m_idle = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        total++; if (bus.ball_x !== 10'd320) begin bad++; $display("FAIL reset_x got=%0d exp=320", bus.ball_x); end
        total++; if (bus.ball_y !== 10'd240) begin bad++; $display("FAIL reset_y got=%0d exp=240", bus.ball_y); end
        total++; if (bus.dir !== 2'b00) begin bad++; $display("FAIL reset_dir got=%b exp=00", bus.dir); end
        total++; if (bus.xstep !== 7'd2 || bus.ystep !== 7'd2) begin bad++; $display("FAIL reset_step got=%0d/%0d exp=2/2", bus.xstep, bus.ystep); end
        total++; if (bus.draw_req !== 1'b0 || bus.ball_lost !== 1'b0 || bus.tick_overrun !== 1'b0) begin
            bad++; $display("FAIL reset_flags got req=%b lost=%b ovr=%b exp=000", bus.draw_req, bus.ball_lost, bus.tick_overrun);
        end
    endtask

    // One frame with collision codes e/o held through the frame; outcome predicted from the model.
    task automatic run_frame(input logic [1:0] e, input logic [1:0] o);
        bit loss;
        int n, lostcnt, reqcnt, ex, ey;
        logic [1:0] edir;
        loss = (e == 2'b11) && (mdir[1] == 1'b0);
        @(negedge clk);
        bus.frame_tick = 1'b1; bus.edge_coll = e; bus.obj_coll = o;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        n = 1; lostcnt = 0; reqcnt = 0;
        if (loss) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.ball_lost) lostcnt++;
                if (bus.draw_req) reqcnt++;
                @(negedge clk);
            end
            model_reset();
            total++; if (lostcnt != 1) begin bad++; $display("FAIL loss_pulse got=%0d cycles exp=1", lostcnt); end
            total++; if (reqcnt != 0) begin bad++; $display("FAIL loss_nodraw got=%0d req cycles exp=0", reqcnt); end
            total++; if (bus.ball_x !== 10'(mx) || bus.ball_y !== 10'(my) || bus.dir !== mdir) begin
                bad++; $display("FAIL loss_reload got=%0d,%0d,%b exp=%0d,%0d,%b", bus.ball_x, bus.ball_y, bus.dir, mx, my, mdir);
            end
        end else begin
            while (!bus.draw_req && n < 20) begin
                if (bus.ball_lost) lostcnt++;
                @(negedge clk);
                n++;
            end
            edir = mdir;
            if (e == 2'b10 || o == 2'b10) edir[0] = ~edir[0];
            if (e == 2'b11 || o == 2'b11) edir[1] = ~edir[1];
            ex = edir[0] ? ((mx < 2) ? 0 : mx - 2) : ((mx + 2 > 639) ? 639 : mx + 2);
            ey = edir[1] ? ((my < 2) ? 0 : my - 2) : ((my + 2 > 479) ? 479 : my + 2);
            mdir = edir; mx = ex; my = ey;
            total++; if (n - 1 != SC + 2) begin bad++; $display("FAIL draw_latency got=%0d exp=%0d", n - 1, SC + 2); end
            total++; if (bus.ball_x !== 10'(mx) || bus.ball_y !== 10'(my) || bus.dir !== mdir || lostcnt != 0) begin
                bad++; $display("FAIL frame_pos got=%0d,%0d,%b lost=%0d exp=%0d,%0d,%b lost=0 (e=%b o=%b)",
                                bus.ball_x, bus.ball_y, bus.dir, lostcnt, mx, my, mdir, e, o);
            end
            total++; if (bus.xstep !== 7'd2 || bus.ystep !== 7'd2) begin bad++; $display("FAIL frame_step got=%0d/%0d exp=2/2", bus.xstep, bus.ystep); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.draw_ack = 1'b1;
            @(negedge clk);
            bus.draw_ack = 1'b0;
            total++; if (bus.draw_req !== 1'b0) begin bad++; $display("FAIL ack_drop got=%b exp=0", bus.draw_req); end
        end
        bus.edge_coll = 2'b00; bus.obj_coll = 2'b00;
    endtask

    task automatic test_loss();
        int reqcnt;
        do_start();
        for (int i = 0; i < 119; i++) run_frame(2'b00, 2'b00);
        total++; if (bus.ball_y !== 10'd478) begin bad++; $display("FAIL loss_setup_y got=%0d exp=478", bus.ball_y); end
        run_frame(2'b11, 2'b00);
        // start and tick together in IDLE: reach WAIT, tick not used, no overrun
        @(negedge clk);
        bus.start = 1'b1; bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.frame_tick = 1'b0;
        m_idle = 1'b0;
        reqcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.draw_req) reqcnt++;
            @(negedge clk);
        end
        total++; if (reqcnt != 0 || bus.tick_overrun !== 1'b0) begin
            bad++; $display("FAIL idle_start_tick got req=%0d ovr=%b exp=0/0", reqcnt, bus.tick_overrun);
        end
        run_frame(2'b00, 2'b00);
    endtask

    task automatic test_x_walk();
        while (mx < 639) run_frame(2'b00, 2'b00);
        run_frame(2'b10, 2'b00);
        total++; if (bus.dir[0] !== 1'b1 || bus.ball_x !== 10'd637) begin bad++; $display("FAIL right_bounce got=%b,%0d exp=1,637", bus.dir[0], bus.ball_x); end
        while (mx > 0) run_frame(2'b00, 2'b00);
        run_frame(2'b10, 2'b00);
        total++; if (bus.dir !== 2'b00 || bus.ball_x !== 10'd2) begin bad++; $display("FAIL left_bounce got=%b,%0d exp=00,2", bus.dir, bus.ball_x); end
    endtask

    task automatic test_dual_hits();
        run_frame(2'b10, 2'b11);
        total++; if (bus.dir !== 2'b11) begin bad++; $display("FAIL edgex_objy got=%b exp=11", bus.dir); end
        run_frame(2'b11, 2'b11);
        total++; if (bus.dir !== 2'b01) begin bad++; $display("FAIL both_y_once got=%b exp=01", bus.dir); end
    endtask

    task automatic test_random();
        logic [1:0] e, o;
        for (int i = 0; i < 80; i++) begin
            if (m_idle) do_start();
            e = 2'($urandom_range(0, 3));
            o = 2'($urandom_range(0, 3));
            run_frame(e, o);
        end
        if (m_idle) do_start();
    endtask

    task automatic test_overrun_and_reset();
        int n;
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        n = 0;
        while (!bus.draw_req && n < 20) begin @(negedge clk); n++; end
        mx = mdir[0] ? ((mx < 2) ? 0 : mx - 2) : ((mx + 2 > 639) ? 639 : mx + 2);
        my = mdir[1] ? ((my < 2) ? 0 : my - 2) : ((my + 2 > 479) ? 479 : my + 2);
        total++; if (bus.draw_req !== 1'b1) begin bad++; $display("FAIL ovr_draw_reached got=%b exp=1", bus.draw_req); end
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (bus.tick_overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%b exp=1", bus.tick_overrun); end
        total++; if (bus.draw_req !== 1'b1 || bus.ball_x !== 10'(mx) || bus.ball_y !== 10'(my)) begin
            bad++; $display("FAIL overrun_hold got req=%b %0d,%0d exp=1 %0d,%0d", bus.draw_req, bus.ball_x, bus.ball_y, mx, my);
        end
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        total++; if (bus.draw_req !== 1'b0 || bus.tick_overrun !== 1'b0 || bus.ball_lost !== 1'b0) begin
            bad++; $display("FAIL middraw_reset_flags got req=%b ovr=%b lost=%b exp=000", bus.draw_req, bus.tick_overrun, bus.ball_lost);
        end
        total++; if (bus.ball_x !== 10'd320 || bus.ball_y !== 10'd240 || bus.dir !== 2'b00) begin
            bad++; $display("FAIL middraw_reset_pos got=%0d,%0d,%b exp=320,240,00", bus.ball_x, bus.ball_y, bus.dir);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.frame_tick = 1'b0; bus.edge_coll = 2'b00;
        bus.obj_coll = 2'b00; bus.draw_ack = 1'b0;
        reset = 1'b1;
        model_reset();
        test_reset();
        test_loss();
        test_x_walk();
        test_dual_hits();
        test_random();
        test_overrun_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
